// File: rtl/rv32i_types.sv
// rv32i_types: shared pipeline types and constants for the fetch stage
package rv32i_types;
  typedef enum logic [1:0] {FETCH, HOLD, DROP} fetch_state_t;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [31:0] PC_RESET = 32'h0000_0060;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry word+pc buffer holding a fetch that returns under stall
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_word,
  input  logic [31:0] d_pc,
  output logic [31:0] word,
  output logic [31:0] pc,
  output logic        valid
);
  always_ff @(posedge clk)
    if (rst) valid <= 1'b0;
    else if (load) valid <= 1'b1;
    else if (clear) valid <= 1'b0;
  always_ff @(posedge clk)
    if (load) begin
      word <= d_word;
      pc <= d_pc;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, I-cache requester and IF/ID register with skid and redirect squash
module fetch_unit #(
  parameter logic [31:0] PC_RESET = rv32i_types::PC_RESET,
  parameter logic [31:0] NOP_WORD = rv32i_types::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_read,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_rdata,
  input  logic        inst_resp,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        flush
);
  import rv32i_types::*;
  fetch_state_t state, state_nx;
  logic [31:0] pc, req_addr, tgt, skid_word, skid_pc;
  logic skid_valid, skid_load, skid_clear, take;
  assign tgt = {redirect_pc[31:2], 2'b00};
  assign take = state == FETCH && inst_resp && !redirect;
  assign skid_load = take && stall;
  assign skid_clear = state == HOLD && (redirect || !stall);
  fetch_skid u_skid (
    .clk(clk),
    .rst(rst),
    .load(skid_load),
    .clear(skid_clear),
    .d_word(inst_rdata),
    .d_pc(req_addr),
    .word(skid_word),
    .pc(skid_pc),
    .valid(skid_valid)
  );
  always_ff @(posedge clk)
    if (rst) state <= FETCH;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      FETCH: state_nx = redirect ? (inst_resp ? FETCH : DROP) : (inst_resp && stall) ? HOLD : FETCH;
      HOLD: state_nx = (redirect || !stall) ? FETCH : HOLD;
      DROP: state_nx = inst_resp ? FETCH : DROP;
      default: state_nx = FETCH;
    endcase
  end
  always_comb begin
    inst_read = state != HOLD;
    inst_addr = req_addr;
  end
  always_ff @(posedge clk)
    if (rst) begin
      pc <= PC_RESET;
      req_addr <= PC_RESET;
    end else
      case (state)
        FETCH:
          if (redirect) begin
            pc <= tgt;
            if (inst_resp) req_addr <= tgt;
          end else if (inst_resp) begin
            pc <= req_addr + 32'd4;
            req_addr <= req_addr + 32'd4;
          end
        HOLD:
          if (redirect) begin
            pc <= tgt;
            req_addr <= tgt;
          end
        DROP: begin
          if (redirect) pc <= tgt;
          if (inst_resp) req_addr <= redirect ? tgt : pc;
        end
        default: ;
      endcase
  always_ff @(posedge clk)
    if (rst) begin
      instr <= NOP_WORD;
      instr_pc <= 32'd0;
      flush <= 1'b1;
    end else if (redirect) begin
      instr <= NOP_WORD;
      flush <= 1'b1;
    end else if (!stall) begin
      instr <= skid_valid ? skid_word : take ? inst_rdata : NOP_WORD;
      instr_pc <= skid_valid ? skid_pc : take ? req_addr : instr_pc;
      flush <= !(skid_valid || take);
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan scenarios plus randomized run against a queue-based reference model
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst = 1'b1, stall = 1'b0, redirect = 1'b0, inst_resp = 1'b0;
  logic [31:0] redirect_pc = 32'd0, inst_rdata = 32'd0;
  logic inst_read, flush;
  logic [31:0] inst_addr, instr, instr_pc;
  int errors = 0, checks = 0;
  logic [31:0] m_pc, m_req, m_instr, m_ipc;
  logic m_flush, m_stale;
  logic [63:0] m_skid[$];
  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .inst_read(inst_read),
    .inst_addr(inst_addr),
    .inst_rdata(inst_rdata),
    .inst_resp(inst_resp),
    .instr(instr),
    .instr_pc(instr_pc),
    .flush(flush)
  );
  always #5 clk = ~clk;
  task automatic model_update();
    logic [31:0] t;
    logic [63:0] s;
    t = {redirect_pc[31:2], 2'b00};
    if (rst) begin
      m_pc = 32'h60; m_req = 32'h60; m_stale = 1'b0; m_skid.delete();
      m_instr = NOP; m_ipc = 32'd0; m_flush = 1'b1;
    end else begin
      if (redirect) begin
        m_instr = NOP; m_flush = 1'b1;
      end else if (!stall) begin
        if (m_skid.size() > 0) begin
          s = m_skid[0]; m_instr = s[63:32]; m_ipc = s[31:0]; m_flush = 1'b0;
        end else if (!m_stale && inst_resp) begin
          m_instr = inst_rdata; m_ipc = m_req; m_flush = 1'b0;
        end else begin
          m_instr = NOP; m_flush = 1'b1;
        end
      end
      if (m_skid.size() > 0) begin
        if (redirect) begin
          m_skid.delete(); m_pc = t; m_req = t;
        end else if (!stall) m_skid.delete();
      end else if (m_stale) begin
        if (redirect) m_pc = t;
        if (inst_resp) begin m_req = m_pc; m_stale = 1'b0; end
      end else if (redirect) begin
        m_pc = t;
        if (inst_resp) m_req = t; else m_stale = 1'b1;
      end else if (inst_resp) begin
        if (stall) m_skid.push_back({inst_rdata, m_req});
        m_req = m_req + 32'd4; m_pc = m_req;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; inst_resp = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", instr, NOP); end
    checks++; if (instr_pc !== 32'd0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL reset_flush: got %b expected 1", flush); end
    checks++; if (inst_read !== 1'b1) begin errors++; $display("FAIL reset_read: got %b expected 1", inst_read); end
    checks++; if (inst_addr !== 32'h60) begin errors++; $display("FAIL reset_addr: got %h expected 60", inst_addr); end
  endtask
  task automatic test_stream();
    tick();
    inst_resp = 1'b1; inst_rdata = 32'h0050_0093;
    tick();
    inst_resp = 1'b0;
    checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL stream_instr: got %h expected 00500093", instr); end
    checks++; if (instr_pc !== 32'h60) begin errors++; $display("FAIL stream_pc: got %h expected 60", instr_pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL stream_flush: got %b expected 0", flush); end
    checks++; if (inst_addr !== 32'h64 || inst_read !== 1'b1) begin errors++; $display("FAIL stream_next_addr: got %h/%b expected 64/1", inst_addr, inst_read); end
  endtask
  task automatic test_stall();
    stall = 1'b1; inst_resp = 1'b1; inst_rdata = 32'h00A0_0113;
    tick();
    inst_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (inst_read !== 1'b0) begin errors++; $display("FAIL stall_read[%0d]: got %b expected 0", i, inst_read); end
      checks++; if (instr !== 32'h0050_0093 || instr_pc !== 32'h60 || flush !== 1'b0) begin errors++; $display("FAIL stall_hold[%0d]: got %h/%h/%b expected 00500093/60/0", i, instr, instr_pc, flush); end
      if (i < 2) tick();
    end
    stall = 1'b0;
    tick();
    checks++; if (instr !== 32'h00A0_0113 || instr_pc !== 32'h64 || flush !== 1'b0) begin errors++; $display("FAIL stall_release: got %h/%h/%b expected 00a00113/64/0", instr, instr_pc, flush); end
    checks++; if (inst_read !== 1'b1 || inst_addr !== 32'h68) begin errors++; $display("FAIL stall_next: got %b/%h expected 1/68", inst_read, inst_addr); end
  endtask
  task automatic test_redirect_outstanding();
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    checks++; if (flush !== 1'b1 || instr !== NOP) begin errors++; $display("FAIL redir_flush: got %h/%b expected %h/1", instr, flush, NOP); end
    checks++; if (inst_read !== 1'b1 || inst_addr !== 32'h68) begin errors++; $display("FAIL redir_stale_addr: got %b/%h expected 1/68", inst_read, inst_addr); end
    tick();
    inst_resp = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    tick();
    inst_resp = 1'b0;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL redir_drop: got flush %b instr %h expected flush 1", flush, instr); end
    checks++; if (inst_addr !== 32'h200) begin errors++; $display("FAIL redir_target_addr: got %h expected 200", inst_addr); end
    tick();
    inst_resp = 1'b1; inst_rdata = 32'h0000_0033;
    tick();
    inst_resp = 1'b0;
    checks++; if (instr !== 32'h33 || instr_pc !== 32'h200 || flush !== 1'b0) begin errors++; $display("FAIL redir_target: got %h/%h/%b expected 33/200/0", instr, instr_pc, flush); end
  endtask
  task automatic test_redirect_coincident();
    redirect = 1'b1; redirect_pc = 32'h203; inst_resp = 1'b1; inst_rdata = 32'h1234_5678;
    tick();
    redirect = 1'b0; inst_resp = 1'b0;
    checks++; if (flush !== 1'b1 || instr !== NOP) begin errors++; $display("FAIL coinc_discard: got %h/%b expected %h/1", instr, flush, NOP); end
    checks++; if (inst_addr !== 32'h200 || inst_read !== 1'b1) begin errors++; $display("FAIL coinc_addr: got %h/%b expected 200/1", inst_addr, inst_read); end
    inst_resp = 1'b1; inst_rdata = 32'h0010_0093;
    tick();
    inst_resp = 1'b0;
    checks++; if (instr !== 32'h0010_0093 || instr_pc !== 32'h200 || flush !== 1'b0) begin errors++; $display("FAIL coinc_target: got %h/%h/%b expected 00100093/200/0", instr, instr_pc, flush); end
  endtask
  task automatic test_redirect_stall();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    stall = 1'b0; redirect = 1'b0;
    checks++; if (flush !== 1'b1 || instr !== NOP) begin errors++; $display("FAIL redir_over_stall: got %h/%b expected %h/1", instr, flush, NOP); end
  endtask
  task automatic test_reset_in_drop();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (inst_addr !== 32'h60 || inst_read !== 1'b1) begin errors++; $display("FAIL drop_rst_addr: got %h/%b expected 60/1", inst_addr, inst_read); end
    checks++; if (flush !== 1'b1 || instr !== NOP || instr_pc !== 32'd0) begin errors++; $display("FAIL drop_rst_out: got %h/%h/%b expected %h/0/1", instr, instr_pc, flush, NOP); end
    inst_resp = 1'b1; inst_rdata = 32'h0020_0113;
    tick();
    inst_resp = 1'b0;
    checks++; if (instr !== 32'h0020_0113 || instr_pc !== 32'h60 || flush !== 1'b0) begin errors++; $display("FAIL drop_rst_late_resp: got %h/%h/%b expected 00200113/60/0", instr, instr_pc, flush); end
  endtask
  task automatic test_random();
    int lat;
    lat = 0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; inst_resp = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      checks++; if (instr !== m_instr) begin errors++; $display("FAIL rand_instr @%0d: got %h expected %h", i, instr, m_instr); end
      checks++; if (instr_pc !== m_ipc) begin errors++; $display("FAIL rand_instr_pc @%0d: got %h expected %h", i, instr_pc, m_ipc); end
      checks++; if (flush !== m_flush) begin errors++; $display("FAIL rand_flush @%0d: got %b expected %b", i, flush, m_flush); end
      checks++; if (inst_read !== (m_skid.size() == 0)) begin errors++; $display("FAIL rand_read @%0d: got %b expected %b", i, inst_read, m_skid.size() == 0); end
      if (m_skid.size() == 0) begin
        checks++; if (inst_addr !== m_req) begin errors++; $display("FAIL rand_addr @%0d: got %h expected %h", i, inst_addr, m_req); end
      end
      rst = $urandom_range(0, 199) == 0;
      stall = $urandom_range(0, 9) < 3;
      redirect = $urandom_range(0, 99) < 8;
      redirect_pc = $urandom_range(0, 7) == 0 ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
      if (!rst && inst_read && lat == 0) begin
        inst_resp = 1'b1; inst_rdata = $urandom; lat = $urandom_range(0, 2);
      end else begin
        inst_resp = 1'b0;
        if (inst_read && lat > 0) lat--;
      end
    end
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; inst_resp = 1'b0;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_outstanding();
    test_redirect_coincident();
    test_redirect_stall();
    test_reset_in_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
